// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
// Shares one single-port, word-addressed data memory between requester 0
// (core load/store) and requester 1 (DMA/debug loader). One access per cycle,
// round-robin on ties, optional bounded lock for read-modify-write sequences.
// The memory is driven combinationally from the granted request; read data
// and error status come back through registered per-requester response ports.

module data_mem_arbiter #(
    parameter int MEM_WORDS = 1024,
    parameter int MAX_LOCK  = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        r0_req,
    input  logic        r0_we,
    input  logic        r0_lock,
    input  logic [31:0] r0_addr,
    input  logic [31:0] r0_wdata,
    output logic        r0_gnt,
    output logic        r0_rvalid,
    output logic [31:0] r0_rdata,
    output logic        r0_err,

    input  logic        r1_req,
    input  logic        r1_we,
    input  logic        r1_lock,
    input  logic [31:0] r1_addr,
    input  logic [31:0] r1_wdata,
    output logic        r1_gnt,
    output logic        r1_rvalid,
    output logic [31:0] r1_rdata,
    output logic        r1_err,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_write,
    input  logic [31:0] mem_read_data
);

    // lock_cnt must be able to hold MAX_LOCK-1; one extra bit of headroom is harmless
    localparam int CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LOCK - 1);

    // state     | meaning
    // ST_ARB    | free arbitration, round-robin on ties
    // ST_LOCKED | only the owner may be granted; bounded by MAX_LOCK grants
    typedef enum logic {
        ST_ARB,
        ST_LOCKED
    } arb_state_t;

    arb_state_t      state;
    arb_state_t      state_nxt;
    logic            owner;
    logic            owner_nxt;
    logic            last_grant;
    logic            last_grant_nxt;
    logic [CNT_W-1:0] lock_cnt;
    logic [CNT_W-1:0] lock_cnt_nxt;

    logic            gnt_any;
    logic            gnt_idx;
    logic            owner_req;
    logic            owner_lock;

    logic            sel_we;
    logic [31:0]     sel_addr;
    logic [31:0]     sel_wdata;
    logic [31:0]     sel_word;
    logic            sel_err;
    logic [31:0]     resp_rdata;

    assign owner_req  = owner ? r1_req  : r0_req;
    assign owner_lock = owner ? r1_lock : r0_lock;

    // Arbitration: grant selection and next arbitration/lock state
    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_grant_nxt = last_grant;
        lock_cnt_nxt   = lock_cnt;
        gnt_any        = 1'b0;
        gnt_idx        = 1'b0;

        case (state)
            ST_ARB: begin
                if (r0_req && r1_req) begin
                    gnt_any = 1'b1;
                    gnt_idx = ~last_grant;
                end else if (r0_req) begin
                    gnt_any = 1'b1;
                    gnt_idx = 1'b0;
                end else if (r1_req) begin
                    gnt_any = 1'b1;
                    gnt_idx = 1'b1;
                end

                if (gnt_any) begin
                    last_grant_nxt = gnt_idx;
                    if (gnt_idx ? r1_lock : r0_lock) begin
                        state_nxt    = ST_LOCKED;
                        owner_nxt    = gnt_idx;
                        lock_cnt_nxt = CNT_ONE;
                    end
                end
            end

            ST_LOCKED: begin
                // The owner is recorded as last grant on every locked cycle,
                // so after any exit the other requester wins the next tie.
                last_grant_nxt = owner;
                if (owner_req) begin
                    gnt_any = 1'b1;
                    gnt_idx = owner;
                end
                if (owner_req && owner_lock && (lock_cnt < CNT_LAST)) begin
                    lock_cnt_nxt = lock_cnt + CNT_ONE;
                end else begin
                    // voluntary release, dropped request, or forced release at the limit
                    state_nxt    = ST_ARB;
                    lock_cnt_nxt = '0;
                end
            end

            default: begin
                state_nxt    = ST_ARB;
                lock_cnt_nxt = '0;
            end
        endcase

        if (reset) begin
            gnt_any = 1'b0;
        end
    end

    assign r0_gnt = gnt_any & ~gnt_idx;
    assign r1_gnt = gnt_any &  gnt_idx;

    assign sel_we    = gnt_idx ? r1_we    : r0_we;
    assign sel_addr  = gnt_idx ? r1_addr  : r0_addr;
    assign sel_wdata = gnt_idx ? r1_wdata : r0_wdata;

    // Word index compared at full width so addresses far above the memory still flag
    assign sel_word = {2'b00, sel_addr[31:2]};
    assign sel_err  = (sel_addr[1:0] != 2'b00) || (sel_word >= 32'(MEM_WORDS));

    assign mem_addr       = gnt_any ? sel_addr  : 32'd0;
    assign mem_write_data = gnt_any ? sel_wdata : 32'd0;
    assign mem_write      = gnt_any & sel_we & ~sel_err & ~reset;

    assign resp_rdata = (sel_we || sel_err) ? 32'd0 : mem_read_data;

    // Arbitration state register; reset discards any lock in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_ARB;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            lock_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_grant <= last_grant_nxt;
            lock_cnt   <= lock_cnt_nxt;
        end
    end

    // Response registers: one-cycle pulse for the requester granted in the ending cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r0_rvalid <= 1'b0;
            r0_rdata  <= 32'd0;
            r0_err    <= 1'b0;
            r1_rvalid <= 1'b0;
            r1_rdata  <= 32'd0;
            r1_err    <= 1'b0;
        end else begin
            r0_rvalid <= r0_gnt;
            r0_rdata  <= r0_gnt ? resp_rdata : 32'd0;
            r0_err    <= r0_gnt & sel_err;
            r1_rvalid <= r1_gnt;
            r1_rdata  <= r1_gnt ? resp_rdata : 32'd0;
            r1_err    <= r1_gnt & sel_err;
        end
    end

    // Grants are mutually exclusive and a write strobe never appears without a grant
    a_gnt_onehot: assert property (@(posedge clk) !(r0_gnt && r1_gnt));
    a_write_needs_gnt: assert property (@(posedge clk) mem_write |-> (r0_gnt || r1_gnt));

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural single-port memory.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.

module tb_data_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        r0_req, r0_we, r0_lock;
    logic [31:0] r0_addr, r0_wdata;
    logic        r0_gnt, r0_rvalid, r0_err;
    logic [31:0] r0_rdata;
    logic        r1_req, r1_we, r1_lock;
    logic [31:0] r1_addr, r1_wdata;
    logic        r1_gnt, r1_rvalid, r1_err;
    logic [31:0] r1_rdata;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;
    logic        mem_write;

    int errors;
    int checks;

    logic [31:0] mem [0:1023];

    data_mem_arbiter #(.MEM_WORDS(1024), .MAX_LOCK(4)) dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_err(r0_err),
        .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_err(r1_err),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_write(mem_write),
        .mem_read_data(mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: preload then posedge writes, all from one process
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] <= 32'h1000_0000 + 32'(i);
        mem[0] <= 32'h0000_000A;
        mem[1] <= 32'h0000_000B;
        forever begin
            @(posedge clk);
            if (mem_write) mem[mem_addr[11:2]] <= mem_write_data;
        end
    end

    // Out-of-range reads return garbage so the DUT's zeroing is observable
    always_comb mem_read_data = (mem_addr[31:12] == 20'd0) ? mem[mem_addr[11:2]] : 32'hBAD0_BAD0;

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        r0_req = 0; r0_we = 0; r0_lock = 0; r0_addr = 0; r0_wdata = 0;
        r1_req = 0; r1_we = 0; r1_lock = 0; r1_addr = 0; r1_wdata = 0;
    endtask

    task automatic test_reset;
        reset = 1;
        r0_req = 1; r0_we = 1; r0_addr = 32'h0; r0_wdata = 32'hDEAD_BEEF;
        r1_req = 1; r1_we = 0; r1_addr = 32'h4;
        @(negedge clk);
        checks++; if ({r0_gnt, r1_gnt} !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", {r0_gnt, r1_gnt}); end
        checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write: got %b expected 0", mem_write); end
        checks++; if ({r0_rvalid, r1_rvalid, r0_err, r1_err} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {r0_rvalid, r1_rvalid, r0_err, r1_err}); end
        checks++; if ((r0_rdata | r1_rdata) !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h/%h expected 0", r0_rdata, r1_rdata); end
        next_cycle();
        checks++; if (mem[0] !== 32'h0000_000A) begin errors++; $display("FAIL reset_mem0: got %h expected 0000000a", mem[0]); end
        idle_inputs();
        reset = 0;
        next_cycle();
    endtask

    task automatic test_tie_after_reset;
        r0_req = 1; r0_addr = 32'h0;
        r1_req = 1; r1_addr = 32'h4;
        @(negedge clk);
        checks++; if ({r0_gnt, r1_gnt} !== 2'b10) begin errors++; $display("FAIL tie_c1_gnt: got %b expected 10", {r0_gnt, r1_gnt}); end
        next_cycle();
        r0_req = 0;
        @(negedge clk);
        checks++; if ({r0_gnt, r1_gnt} !== 2'b01) begin errors++; $display("FAIL tie_c2_gnt: got %b expected 01", {r0_gnt, r1_gnt}); end
        checks++; if (r0_rvalid !== 1'b1 || r0_rdata !== 32'hA) begin errors++; $display("FAIL tie_c2_r0_resp: got v=%b d=%h expected v=1 d=0000000a", r0_rvalid, r0_rdata); end
        next_cycle();
        r1_req = 0;
        @(negedge clk);
        checks++; if (r1_rvalid !== 1'b1 || r1_rdata !== 32'hB) begin errors++; $display("FAIL tie_c3_r1_resp: got v=%b d=%h expected v=1 d=0000000b", r1_rvalid, r1_rdata); end
        checks++; if (r0_rvalid !== 1'b0) begin errors++; $display("FAIL tie_c3_r0_rvalid: got %b expected 0", r0_rvalid); end
        next_cycle();
    endtask

    task automatic test_read_after_write;
        r1_req = 1; r1_we = 1; r1_addr = 32'h8; r1_wdata = 32'h1234;
        @(negedge clk);
        checks++; if (r1_gnt !== 1'b1 || mem_write !== 1'b1) begin errors++; $display("FAIL raw_write_strobe: got gnt=%b we=%b expected 1/1", r1_gnt, mem_write); end
        checks++; if (mem_addr !== 32'h8 || mem_write_data !== 32'h1234) begin errors++; $display("FAIL raw_mem_bus: got a=%h d=%h expected 00000008/00001234", mem_addr, mem_write_data); end
        next_cycle();
        idle_inputs();
        r0_req = 1; r0_addr = 32'h8;
        @(negedge clk);
        checks++; if (r0_gnt !== 1'b1) begin errors++; $display("FAIL raw_read_gnt: got %b expected 1", r0_gnt); end
        checks++; if (r1_rvalid !== 1'b1 || r1_rdata !== 32'd0 || r1_err !== 1'b0) begin errors++; $display("FAIL raw_write_resp: got v=%b d=%h e=%b expected 1/0/0", r1_rvalid, r1_rdata, r1_err); end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++; if (r0_rvalid !== 1'b1 || r0_rdata !== 32'h1234) begin errors++; $display("FAIL raw_read_data: got v=%b d=%h expected 1/00001234", r0_rvalid, r0_rdata); end
        next_cycle();
    endtask

    task automatic test_lock_max;
        r0_req = 1; r0_lock = 1; r0_addr = 32'h0;
        @(negedge clk);
        checks++; if ({r0_gnt, r1_gnt} !== 2'b10) begin errors++; $display("FAIL lock_c1_gnt: got %b expected 10", {r0_gnt, r1_gnt}); end
        for (int c = 2; c <= 4; c++) begin
            next_cycle();
            r1_req = 1; r1_addr = 32'h4;
            @(negedge clk);
            checks++; if ({r0_gnt, r1_gnt} !== 2'b10) begin errors++; $display("FAIL lock_c%0d_gnt: got %b expected 10", c, {r0_gnt, r1_gnt}); end
            checks++; if (r0_rvalid !== 1'b1 || r0_rdata !== 32'hA) begin errors++; $display("FAIL lock_c%0d_resp: got v=%b d=%h expected 1/0000000a", c, r0_rvalid, r0_rdata); end
        end
        next_cycle();
        @(negedge clk);
        checks++; if ({r0_gnt, r1_gnt} !== 2'b01) begin errors++; $display("FAIL lock_c5_gnt: got %b expected 01", {r0_gnt, r1_gnt}); end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++; if (r1_rvalid !== 1'b1 || r1_rdata !== 32'hB || r0_rvalid !== 1'b0) begin errors++; $display("FAIL lock_c6_resp: got v1=%b d1=%h v0=%b expected 1/0000000b/0", r1_rvalid, r1_rdata, r0_rvalid); end
        next_cycle();
    endtask

    task automatic test_lock_early_release;
        r1_req = 1; r1_lock = 1; r1_addr = 32'h4;
        @(negedge clk);
        checks++; if ({r0_gnt, r1_gnt} !== 2'b01) begin errors++; $display("FAIL early_c1_gnt: got %b expected 01", {r0_gnt, r1_gnt}); end
        next_cycle();
        r1_lock = 0;
        r0_req = 1; r0_addr = 32'h0;
        @(negedge clk);
        checks++; if ({r0_gnt, r1_gnt} !== 2'b01) begin errors++; $display("FAIL early_c2_gnt: got %b expected 01", {r0_gnt, r1_gnt}); end
        next_cycle();
        @(negedge clk);
        checks++; if ({r0_gnt, r1_gnt} !== 2'b10) begin errors++; $display("FAIL early_c3_gnt: got %b expected 10", {r0_gnt, r1_gnt}); end
        next_cycle();
        r0_req = 0;
        @(negedge clk);
        checks++; if ({r0_gnt, r1_gnt} !== 2'b01) begin errors++; $display("FAIL early_c4_gnt: got %b expected 01", {r0_gnt, r1_gnt}); end
        checks++; if (r0_rvalid !== 1'b1 || r0_rdata !== 32'hA) begin errors++; $display("FAIL early_c4_r0_resp: got v=%b d=%h expected 1/0000000a", r0_rvalid, r0_rdata); end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_errors;
        r0_req = 1; r0_we = 1; r0_addr = 32'h6; r0_wdata = 32'h5555;
        @(negedge clk);
        checks++; if (r0_gnt !== 1'b1 || mem_write !== 1'b0) begin errors++; $display("FAIL err_misalign_write: got gnt=%b we=%b expected 1/0", r0_gnt, mem_write); end
        next_cycle();
        idle_inputs();
        r1_req = 1; r1_addr = 32'h1000;
        @(negedge clk);
        checks++; if (r1_gnt !== 1'b1 || mem_write !== 1'b0) begin errors++; $display("FAIL err_range_read_gnt: got gnt=%b we=%b expected 1/0", r1_gnt, mem_write); end
        checks++; if (r0_rvalid !== 1'b1 || r0_err !== 1'b1 || r0_rdata !== 32'd0) begin errors++; $display("FAIL err_misalign_resp: got v=%b e=%b d=%h expected 1/1/0", r0_rvalid, r0_err, r0_rdata); end
        checks++; if (mem[1] !== 32'hB) begin errors++; $display("FAIL err_mem_unchanged: got %h expected 0000000b", mem[1]); end
        next_cycle();
        idle_inputs();
        r0_req = 1; r0_addr = 32'hFFC;
        @(negedge clk);
        checks++; if (r1_rvalid !== 1'b1 || r1_err !== 1'b1 || r1_rdata !== 32'd0) begin errors++; $display("FAIL err_range_resp: got v=%b e=%b d=%h expected 1/1/0", r1_rvalid, r1_err, r1_rdata); end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++; if (r0_rvalid !== 1'b1 || r0_err !== 1'b0 || r0_rdata !== 32'h1000_03FF) begin errors++; $display("FAIL err_last_word: got v=%b e=%b d=%h expected 1/0/100003ff", r0_rvalid, r0_err, r0_rdata); end
        next_cycle();
    endtask

    task automatic test_reset_mid_lock;
        r0_req = 1; r0_lock = 1; r0_addr = 32'h0;
        @(negedge clk);
        checks++; if ({r0_gnt, r1_gnt} !== 2'b10) begin errors++; $display("FAIL rstlock_c1_gnt: got %b expected 10", {r0_gnt, r1_gnt}); end
        next_cycle();
        reset = 1;
        r0_we = 1; r0_addr = 32'hC; r0_wdata = 32'h7777;
        r1_req = 1; r1_addr = 32'h10;
        @(negedge clk);
        checks++; if ({r0_gnt, r1_gnt, mem_write} !== 3'b000) begin errors++; $display("FAIL rstlock_c2_gated: got %b expected 000", {r0_gnt, r1_gnt, mem_write}); end
        next_cycle();
        reset = 0;
        r0_lock = 0;
        @(negedge clk);
        checks++; if (mem[3] !== 32'h1000_0003) begin errors++; $display("FAIL rstlock_mem_unchanged: got %h expected 10000003", mem[3]); end
        checks++; if ({r0_rvalid, r1_rvalid} !== 2'b00 || r0_rdata !== 32'd0) begin errors++; $display("FAIL rstlock_resp_cleared: got v=%b d=%h expected 00/0", {r0_rvalid, r1_rvalid}, r0_rdata); end
        checks++; if ({r0_gnt, r1_gnt} !== 2'b10) begin errors++; $display("FAIL rstlock_first_tie: got %b expected 10", {r0_gnt, r1_gnt}); end
        next_cycle();
        r0_req = 0; r0_we = 0;
        @(negedge clk);
        checks++; if ({r0_gnt, r1_gnt} !== 2'b01) begin errors++; $display("FAIL rstlock_c4_gnt: got %b expected 01", {r0_gnt, r1_gnt}); end
        checks++; if (mem[3] !== 32'h7777) begin errors++; $display("FAIL rstlock_write_after: got %h expected 00007777", mem[3]); end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++; if (r1_rvalid !== 1'b1 || r1_rdata !== 32'h1000_0004) begin errors++; $display("FAIL rstlock_c5_r1_resp: got v=%b d=%h expected 1/10000004", r1_rvalid, r1_rdata); end
        next_cycle();
    endtask

    task automatic test_back_to_back;
        for (int k = 0; k < 8; k++) begin
            r1_req = 1; r1_addr = 32'h20 + 32'(4 * k);
            @(negedge clk);
            checks++; if ({r0_gnt, r1_gnt} !== 2'b01) begin errors++; $display("FAIL stream_gnt_%0d: got %b expected 01", k, {r0_gnt, r1_gnt}); end
            if (k > 0) begin
                checks++; if (r1_rvalid !== 1'b1 || r1_rdata !== 32'h1000_0000 + 32'(7 + k)) begin errors++; $display("FAIL stream_resp_%0d: got v=%b d=%h expected 1/%h", k - 1, r1_rvalid, r1_rdata, 32'h1000_0000 + 32'(7 + k)); end
            end
            next_cycle();
        end
        idle_inputs();
        @(negedge clk);
        checks++; if (r1_rvalid !== 1'b1 || r1_rdata !== 32'h1000_000F) begin errors++; $display("FAIL stream_resp_7: got v=%b d=%h expected 1/1000000f", r1_rvalid, r1_rdata); end
        next_cycle();
        @(negedge clk);
        checks++; if (r1_rvalid !== 1'b0) begin errors++; $display("FAIL stream_end_rvalid: got %b expected 0", r1_rvalid); end
        next_cycle();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1;
        idle_inputs();
        next_cycle();
        test_reset();
        test_tie_after_reset();
        test_read_after_write();
        test_lock_max();
        test_lock_early_release();
        test_errors();
        test_reset_mid_lock();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
